// File: rtl/seg_scan_ctrl_pkg.sv
// Segment code constants and helpers shared by the 7-segment scan controller.
// All codes are active-low {g,f,e,d,c,b,a}.
package seg_pkg;

    typedef logic [6:0] seg_code_t;

    localparam seg_code_t SEG_BLANK = 7'h7F;
    localparam seg_code_t HEX0 = 7'h40;
    localparam seg_code_t HEX1 = 7'h79;
    localparam seg_code_t HEX2 = 7'h24;
    localparam seg_code_t HEX3 = 7'h30;
    localparam seg_code_t HEX4 = 7'h19;
    localparam seg_code_t HEX5 = 7'h12;
    localparam seg_code_t HEX6 = 7'h02;
    localparam seg_code_t HEX7 = 7'h78;
    localparam seg_code_t HEX8 = 7'h00;
    localparam seg_code_t HEX9 = 7'h10;
    localparam seg_code_t HEXA = 7'h08;
    localparam seg_code_t HEXB = 7'h03;
    localparam seg_code_t HEXC = 7'h46;
    localparam seg_code_t HEXD = 7'h21;
    localparam seg_code_t HEXE = 7'h06;
    localparam seg_code_t HEXF = 7'h0E;

    function automatic int unsigned idx_w(input int unsigned n);
        return $clog2(n);
    endfunction

endpackage

// File: rtl/seg_scan_ctrl_if.sv
// Bundle of the scan strobe, digit data and display pin outputs.
// master drives tick/data and observes the pins; slave is the controller.
interface seg_scan_ctrl_if #(
    parameter int NUM_DIGITS = 8
);
    import seg_pkg::*;

    logic                      tick;
    logic [4*NUM_DIGITS-1:0]   digits;
    logic [NUM_DIGITS-1:0]     dp_en;
    logic [NUM_DIGITS-1:0]     digit_en;
    logic [NUM_DIGITS-1:0]     an;
    seg_code_t                 seg;
    logic                      dp;
    logic                      frame_start;

    modport master (
        output tick, digits, dp_en, digit_en,
        input  an, seg, dp, frame_start
    );

    modport slave (
        input  tick, digits, dp_en, digit_en,
        output an, seg, dp, frame_start
    );

endinterface

// File: rtl/seg_scan_ctrl_hex_to_seg.sv
// Combinational hex nibble to active-low 7-segment decoder.
module hex_to_seg
    import seg_pkg::*;
(
    input  logic [3:0] nibble,
    output seg_code_t  code
);

    always_comb begin
        code = SEG_BLANK;
        unique case (nibble)
            4'h0: code = HEX0;
            4'h1: code = HEX1;
            4'h2: code = HEX2;
            4'h3: code = HEX3;
            4'h4: code = HEX4;
            4'h5: code = HEX5;
            4'h6: code = HEX6;
            4'h7: code = HEX7;
            4'h8: code = HEX8;
            4'h9: code = HEX9;
            4'hA: code = HEXA;
            4'hB: code = HEXB;
            4'hC: code = HEXC;
            4'hD: code = HEXD;
            4'hE: code = HEXE;
            4'hF: code = HEXF;
            default: code = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Multiplexed N-digit 7-segment scan controller: one digit per tick, anode
// guard blanking at every digit change, per-frame snapshot of digit data.
module seg_scan_ctrl
    import seg_pkg::*;
#(
    parameter int NUM_DIGITS = 8,
    parameter int GUARD_CYC  = 2
) (
    input  logic                 clk_in,
    input  logic                 reset,
    seg_scan_ctrl_if.slave       bus
);

    localparam int unsigned     IW       = idx_w(NUM_DIGITS);
    localparam logic [IW-1:0]   LAST     = IW'(NUM_DIGITS - 1);
    localparam logic [7:0]      GUARD_LD = 8'(GUARD_CYC);

    logic [IW-1:0]             idx;
    logic [7:0]                guard_cnt;
    logic [4*NUM_DIGITS-1:0]   sh_dig;
    logic [NUM_DIGITS-1:0]     sh_dp;
    logic [NUM_DIGITS-1:0]     sh_en;

    logic [NUM_DIGITS-1:0]     an_q;
    seg_code_t                 seg_q;
    logic                      dp_q;
    logic                      fs_q;

    logic                      wrap;
    logic                      light;
    logic [IW-1:0]             idx_next;
    logic [IW-1:0]             eff_idx;
    logic [4*NUM_DIGITS-1:0]   eff_dig;
    logic [NUM_DIGITS-1:0]     eff_dp;
    logic [NUM_DIGITS-1:0]     eff_en;
    logic [3:0]                nibble;
    seg_code_t                 dec_code;
    logic [NUM_DIGITS-1:0]     onehot;
    logic [NUM_DIGITS-1:0]     lit_an;
    seg_code_t                 lit_seg;
    logic                      lit_dp;

    // With a zero guard the slot lights on the tick edge itself, so the
    // display values are always computed from the post-edge index/snapshot.
    always_comb begin
        wrap     = bus.tick && (idx == LAST);
        idx_next = (idx == LAST) ? '0 : idx + IW'(1);
        eff_idx  = bus.tick ? idx_next : idx;
        eff_dig  = wrap ? bus.digits   : sh_dig;
        eff_dp   = wrap ? bus.dp_en    : sh_dp;
        eff_en   = wrap ? bus.digit_en : sh_en;
        light    = bus.tick ? (GUARD_CYC == 0) : (guard_cnt == 8'd1);
        nibble   = eff_dig[{eff_idx, 2'b00} +: 4];
        onehot   = {{(NUM_DIGITS-1){1'b0}}, 1'b1} << eff_idx;
    end

    hex_to_seg u_hex_to_seg (
        .nibble (nibble),
        .code   (dec_code)
    );

    always_comb begin
        lit_an  = '1;
        lit_seg = SEG_BLANK;
        lit_dp  = 1'b1;
        if (eff_en[eff_idx]) begin
            lit_an  = ~onehot;
            lit_seg = dec_code;
            lit_dp  = ~eff_dp[eff_idx];
        end
    end

    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            idx       <= LAST;
            guard_cnt <= '0;
            sh_dig    <= '0;
            sh_dp     <= '0;
            sh_en     <= '0;
            an_q      <= '1;
            seg_q     <= SEG_BLANK;
            dp_q      <= 1'b1;
            fs_q      <= 1'b0;
        end else begin
            fs_q <= wrap;
            if (bus.tick) begin
                idx       <= idx_next;
                guard_cnt <= GUARD_LD;
                if (wrap) begin
                    sh_dig <= bus.digits;
                    sh_dp  <= bus.dp_en;
                    sh_en  <= bus.digit_en;
                end
            end else if (guard_cnt != 8'd0) begin
                guard_cnt <= guard_cnt - 8'd1;
            end

            if (light) begin
                an_q  <= lit_an;
                seg_q <= lit_seg;
                dp_q  <= lit_dp;
            end else if (bus.tick) begin
                an_q  <= '1;
                seg_q <= SEG_BLANK;
                dp_q  <= 1'b1;
            end
        end
    end

    assign bus.an          = an_q;
    assign bus.seg         = seg_q;
    assign bus.dp          = dp_q;
    assign bus.frame_start = fs_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed bench for seg_scan_ctrl: per-cycle vector table for the main scan
// path plus hand sequences for blanking, held tick, async reset, zero guard.
module tb_seg_scan_ctrl;

    localparam logic [31:0] D0 = 32'h7654_3210;
    localparam logic [31:0] DF = 32'hFFFF_FFFF;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    seg_scan_ctrl_if #(.NUM_DIGITS(8)) bus ();
    seg_scan_ctrl_if #(.NUM_DIGITS(4)) bus2 ();

    seg_scan_ctrl #(.NUM_DIGITS(8), .GUARD_CYC(2)) dut (
        .clk_in (clk),
        .reset  (reset),
        .bus    (bus)
    );

    seg_scan_ctrl #(.NUM_DIGITS(4), .GUARD_CYC(0)) dut0 (
        .clk_in (clk),
        .reset  (reset),
        .bus    (bus2)
    );

    typedef struct {
        logic        tick;
        logic [31:0] digits;
        logic [7:0]  an;
        logic [6:0]  seg;
        logic        dp;
        logic        fs;
    } vec_t;

    vec_t tbl [28];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name,
                         input logic [15:0] a_act, input logic [15:0] a_exp,
                         input logic [6:0] s_act, input logic [6:0] s_exp,
                         input logic d_act, input logic d_exp,
                         input logic f_act, input logic f_exp);
        checks++;
        if ({a_act, s_act, d_act, f_act} !== {a_exp, s_exp, d_exp, f_exp}) begin
            errors++;
            $display("FAIL %s: got an=%h seg=%h dp=%b fs=%b, want an=%h seg=%h dp=%b fs=%b",
                     name, a_act, s_act, d_act, f_act, a_exp, s_exp, d_exp, f_exp);
        end
    endtask

    task automatic chk8(input string name, input logic [7:0] a, input logic [6:0] s,
                        input logic d, input logic f);
        check(name, {8'h00, bus.an}, {8'h00, a}, bus.seg, s, bus.dp, d, bus.frame_start, f);
    endtask

    task automatic chk4(input string name, input logic [3:0] a, input logic [6:0] s,
                        input logic d, input logic f);
        check(name, {12'h000, bus2.an}, {12'h000, a}, bus2.seg, s, bus2.dp, d, bus2.frame_start, f);
    endtask

    // One-cycle tick followed by enough idle cycles for the guard to expire.
    task automatic pulse();
        bus.tick = 1'b1;
        step();
        bus.tick = 1'b0;
        step();
        step();
    endtask

    initial begin
        tbl[0]  = '{1'b1, D0, 8'hFF, 7'h7F, 1'b1, 1'b1};
        tbl[1]  = '{1'b0, D0, 8'hFF, 7'h7F, 1'b1, 1'b0};
        tbl[2]  = '{1'b0, D0, 8'hFE, 7'h40, 1'b0, 1'b0};
        tbl[3]  = '{1'b0, D0, 8'hFE, 7'h40, 1'b0, 1'b0};
        tbl[4]  = '{1'b1, D0, 8'hFF, 7'h7F, 1'b1, 1'b0};
        tbl[5]  = '{1'b0, D0, 8'hFF, 7'h7F, 1'b1, 1'b0};
        tbl[6]  = '{1'b0, D0, 8'hFD, 7'h79, 1'b1, 1'b0};
        tbl[7]  = '{1'b1, D0, 8'hFF, 7'h7F, 1'b1, 1'b0};
        tbl[8]  = '{1'b0, D0, 8'hFF, 7'h7F, 1'b1, 1'b0};
        tbl[9]  = '{1'b0, D0, 8'hFB, 7'h24, 1'b1, 1'b0};
        tbl[10] = '{1'b1, D0, 8'hFF, 7'h7F, 1'b1, 1'b0};
        tbl[11] = '{1'b0, DF, 8'hFF, 7'h7F, 1'b1, 1'b0};
        tbl[12] = '{1'b0, DF, 8'hF7, 7'h30, 1'b1, 1'b0};
        tbl[13] = '{1'b1, DF, 8'hFF, 7'h7F, 1'b1, 1'b0};
        tbl[14] = '{1'b0, DF, 8'hFF, 7'h7F, 1'b1, 1'b0};
        tbl[15] = '{1'b0, DF, 8'hEF, 7'h19, 1'b1, 1'b0};
        tbl[16] = '{1'b1, DF, 8'hFF, 7'h7F, 1'b1, 1'b0};
        tbl[17] = '{1'b0, DF, 8'hFF, 7'h7F, 1'b1, 1'b0};
        tbl[18] = '{1'b0, DF, 8'hDF, 7'h12, 1'b1, 1'b0};
        tbl[19] = '{1'b1, DF, 8'hFF, 7'h7F, 1'b1, 1'b0};
        tbl[20] = '{1'b0, DF, 8'hFF, 7'h7F, 1'b1, 1'b0};
        tbl[21] = '{1'b0, DF, 8'hBF, 7'h02, 1'b1, 1'b0};
        tbl[22] = '{1'b1, DF, 8'hFF, 7'h7F, 1'b1, 1'b0};
        tbl[23] = '{1'b0, DF, 8'hFF, 7'h7F, 1'b1, 1'b0};
        tbl[24] = '{1'b0, DF, 8'h7F, 7'h78, 1'b1, 1'b0};
        tbl[25] = '{1'b1, DF, 8'hFF, 7'h7F, 1'b1, 1'b1};
        tbl[26] = '{1'b0, DF, 8'hFF, 7'h7F, 1'b1, 1'b0};
        tbl[27] = '{1'b0, DF, 8'hFE, 7'h0E, 1'b0, 1'b0};

        bus.tick      = 1'b0;
        bus.digits    = D0;
        bus.dp_en     = 8'h01;
        bus.digit_en  = 8'hFF;
        bus2.tick     = 1'b0;
        bus2.digits   = 16'h3210;
        bus2.dp_en    = 4'h1;
        bus2.digit_en = 4'hF;

        // Reset state and idle without ticks
        step();
        step();
        chk8("reset_state", 8'hFF, 7'h7F, 1'b1, 1'b0);
        reset = 1'b0;
        for (int i = 0; i < 100; i++) begin
            step();
            if (i % 25 == 24) chk8($sformatf("idle_%0d", i), 8'hFF, 7'h7F, 1'b1, 1'b0);
        end

        // Scan path and snapshot isolation
        for (int i = 0; i < 28; i++) begin
            bus.tick   = tbl[i].tick;
            bus.digits = tbl[i].digits;
            step();
            chk8($sformatf("vec%0d", i), tbl[i].an, tbl[i].seg, tbl[i].dp, tbl[i].fs);
        end
        bus.tick = 1'b0;

        // Disabled slot 5 (captured at next wrap)
        bus.digits   = D0;
        bus.digit_en = 8'hDF;
        for (int i = 0; i < 7; i++) pulse();
        bus.tick = 1'b1;
        step();
        chk8("wrap2_fs", 8'hFF, 7'h7F, 1'b1, 1'b1);
        bus.tick = 1'b0;
        step();
        step();
        chk8("wrap2_slot0", 8'hFE, 7'h40, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) pulse();
        chk8("slot4_lit", 8'hEF, 7'h19, 1'b1, 1'b0);
        bus.tick = 1'b1;
        step();
        bus.tick = 1'b0;
        for (int i = 0; i < 6; i++) begin
            step();
            chk8($sformatf("slot5_dark_%0d", i), 8'hFF, 7'h7F, 1'b1, 1'b0);
        end
        pulse();
        chk8("slot6_lit", 8'hBF, 7'h02, 1'b1, 1'b0);

        // Tick held for three cycles from idx 1
        pulse();
        pulse();
        pulse();
        chk8("slot1_lit", 8'hFD, 7'h79, 1'b1, 1'b0);
        bus.tick = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk8($sformatf("held_%0d", i), 8'hFF, 7'h7F, 1'b1, 1'b0);
        end
        bus.tick = 1'b0;
        step();
        chk8("held_guard", 8'hFF, 7'h7F, 1'b1, 1'b0);
        step();
        chk8("held_slot4", 8'hEF, 7'h19, 1'b1, 1'b0);

        // Asynchronous reset mid-frame
        step();
        #2;
        reset = 1'b1;
        #1;
        chk8("async_reset", 8'hFF, 7'h7F, 1'b1, 1'b0);
        step();
        reset = 1'b0;
        bus.digits  = 32'h0000_00A5;
        bus.dp_en   = 8'h00;
        bus.digit_en = 8'hFF;
        step();
        chk8("post_reset_dark", 8'hFF, 7'h7F, 1'b1, 1'b0);
        bus.tick = 1'b1;
        step();
        chk8("post_reset_fs", 8'hFF, 7'h7F, 1'b1, 1'b1);
        bus.tick = 1'b0;
        step();
        step();
        chk8("post_reset_slot0", 8'hFE, 7'h12, 1'b1, 1'b0);

        // Zero guard, 4 digits, tick held across a wrap
        chk4("g0_idle", 4'hF, 7'h7F, 1'b1, 1'b0);
        bus2.tick = 1'b1;
        step();
        chk4("g0_slot0", 4'hE, 7'h40, 1'b0, 1'b1);
        step();
        chk4("g0_slot1", 4'hD, 7'h79, 1'b1, 1'b0);
        step();
        chk4("g0_slot2", 4'hB, 7'h24, 1'b1, 1'b0);
        step();
        chk4("g0_slot3", 4'h7, 7'h30, 1'b1, 1'b0);
        step();
        chk4("g0_wrap", 4'hE, 7'h40, 1'b0, 1'b1);
        bus2.tick = 1'b0;
        step();
        chk4("g0_hold", 4'hE, 7'h40, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
